// File: rtl/tm_slave_tag_responder.sv
// Slave-side credit shell: forwards tagged requests to a module and stamps each
// in-order module response with the {tag, src, vc} context of its request.
module tm_slave_tag_responder #(
    parameter int WIDTH_TAG        = 8,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 2,
    parameter int WIDTH_DATA_IN    = 36,
    parameter int WIDTH_DATA_OUT   = 36,
    parameter int DEPTH            = 8
) (
    input  logic                          clk,
    input  logic                          preset_full,
    input  logic                          req_valid_in,
    output logic                          req_ready_out,
    input  logic [WIDTH_DATA_IN-1:0]      req_data_in,
    input  logic [WIDTH_TAG-1:0]          req_tag_in,
    input  logic [ADDRESS_WIDTH-1:0]      req_src_in,
    input  logic [VC_ADDRESS_WIDTH-1:0]   req_vc_in,
    output logic                          req_valid_out,
    input  logic                          req_ready_in,
    output logic [WIDTH_DATA_IN-1:0]      req_data_out,
    input  logic                          rsp_valid_in,
    output logic                          rsp_ready_out,
    input  logic [WIDTH_DATA_OUT-1:0]     rsp_data_in,
    output logic                          rsp_valid_out,
    input  logic                          rsp_ready_in,
    output logic [WIDTH_DATA_OUT-1:0]     rsp_data_out,
    output logic [WIDTH_TAG-1:0]          rsp_tag_out,
    output logic [ADDRESS_WIDTH-1:0]      rsp_dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]   rsp_vc_out,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding,
    output logic                          orphan_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH_TAG-1:0]        tag;
        logic [ADDRESS_WIDTH-1:0]    src;
        logic [VC_ADDRESS_WIDTH-1:0] vc;
    } ctx_t;

    ctx_t                      ctx_q [DEPTH];
    ctx_t                      ctx_d [DEPTH];
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                      ov_q, ov_d;
    logic                      orphan_q, orphan_d;
    logic [WIDTH_DATA_OUT-1:0] data_q, data_d;
    ctx_t                      out_ctx_q, out_ctx_d;

    logic can_issue, push, rsp_acc, pop, orphan;

    assign can_issue     = cnt_q < CW'(DEPTH);
    assign req_valid_out = req_valid_in & can_issue;
    assign req_ready_out = req_ready_in & can_issue;
    assign req_data_out  = req_data_in;
    assign rsp_ready_out = ~ov_q | rsp_ready_in;

    assign push    = req_valid_in & req_ready_out;
    assign rsp_acc = rsp_valid_in & rsp_ready_out;
    // Contexts become visible only after the push edge, so a response in the
    // same cycle as the first push into an empty FIFO is an orphan.
    assign pop     = rsp_acc & (cnt_q != '0);
    assign orphan  = rsp_acc & (cnt_q == '0);

    always_comb begin
        ctx_d     = ctx_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ov_d      = ov_q;
        orphan_d  = orphan_q | orphan;
        data_d    = data_q;
        out_ctx_d = out_ctx_q;
        if (push) begin
            ctx_d[wr_ptr_q] = '{tag: req_tag_in, src: req_src_in, vc: req_vc_in};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            data_d    = rsp_data_in;
            out_ctx_d = ctx_q[rd_ptr_q];
            ov_d      = 1'b1;
            rd_ptr_d  = rd_ptr_q + PW'(1);
        end else if (rsp_ready_in) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            for (int i = 0; i < DEPTH; i++) ctx_q[i] <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ov_q      <= 1'b0;
            orphan_q  <= 1'b0;
            data_q    <= '0;
            out_ctx_q <= '0;
        end else begin
            ctx_q     <= ctx_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ov_q      <= ov_d;
            orphan_q  <= orphan_d;
            data_q    <= data_d;
            out_ctx_q <= out_ctx_d;
        end
    end

    assign rsp_valid_out = ov_q;
    assign rsp_data_out  = data_q;
    assign rsp_tag_out   = out_ctx_q.tag;
    assign rsp_dst_out   = out_ctx_q.src;
    assign rsp_vc_out    = out_ctx_q.vc;
    assign outstanding   = cnt_q;
    assign orphan_err    = orphan_q;
endmodule
